// File: rtl/ex_operand_stage.sv
// Registered operand-issue stage feeding the ALU: forwarding, operand select, 2-entry skid buffer.
// Build option: define EX_FWD_EN to enable single-source result forwarding.
module ex_operand_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] qa,
    input  logic [WIDTH-1:0] qb,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [15:0]      imm,
    input  logic [4:0]       sa,
    input  logic             shift,
    input  logic             aluimm,
    input  logic             sext,
    input  logic [3:0]       aluc_in,
    input  logic             wreg_in,
    input  logic [4:0]       rn_in,
    input  logic             fwd_valid,
    input  logic [4:0]       fwd_rn,
    input  logic [WIDTH-1:0] fwd_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [3:0]       aluc,
    output logic             wreg,
    output logic [4:0]       rn
);

    function automatic logic [WIDTH-1:0] ext_imm(input logic [15:0] v, input logic se);
        return {{(WIDTH-16){se & v[15]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] fwd_pick(input logic [4:0] r, input logic [WIDTH-1:0] q,
                                                  input logic fv, input logic [4:0] fr,
                                                  input logic [WIDTH-1:0] fd);
        return (fv && fr == r && r != 5'd0) ? fd : q;
    endfunction

    logic [WIDTH-1:0] ra_p0, rb_p0, a_p0, b_p0;

`ifdef EX_FWD_EN
    assign ra_p0 = fwd_pick(rs, qa, fwd_valid, fwd_rn, fwd_data);
    assign rb_p0 = fwd_pick(rt, qb, fwd_valid, fwd_rn, fwd_data);
`else
    // Bypass disabled: ports stay for interface compatibility but carry no function.
    logic fwd_unused;
    assign fwd_unused = ^{fwd_valid, fwd_rn, fwd_data, rs, rt};
    assign ra_p0 = qa;
    assign rb_p0 = qb;
`endif

    assign a_p0 = shift  ? {{(WIDTH-5){1'b0}}, sa} : ra_p0;
    assign b_p0 = aluimm ? ext_imm(imm, sext)       : rb_p0;

    // ---- stage p1: main register (drives outputs) and skid register ----
    logic             vld_p1, vld_skid;
    logic [WIDTH-1:0] a_p1, b_p1, a_skid, b_skid;
    logic [3:0]       aluc_p1, aluc_skid;
    logic             wreg_p1, wreg_skid;
    logic [4:0]       rn_p1, rn_skid;

    logic accept, xfer, load_main_new, load_main_skid, load_skid;

    assign accept         = in_valid && in_ready;
    assign xfer           = vld_p1 && out_ready;
    assign load_main_new  = accept && (!vld_p1 || xfer);
    assign load_main_skid = vld_skid && xfer;
    assign load_skid      = accept && vld_p1 && !out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld_p1   <= 1'b0;
            vld_skid <= 1'b0;
        end else begin
            vld_p1   <= load_main_new || load_main_skid || (vld_p1 && !out_ready);
            vld_skid <= load_skid || (vld_skid && !xfer);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_p1    <= '0;
            b_p1    <= '0;
            aluc_p1 <= '0;
            wreg_p1 <= 1'b0;
            rn_p1   <= '0;
        end else if (load_main_skid) begin
            a_p1    <= a_skid;
            b_p1    <= b_skid;
            aluc_p1 <= aluc_skid;
            wreg_p1 <= wreg_skid;
            rn_p1   <= rn_skid;
        end else if (load_main_new) begin
            a_p1    <= a_p0;
            b_p1    <= b_p0;
            aluc_p1 <= aluc_in;
            wreg_p1 <= wreg_in;
            rn_p1   <= rn_in;
        end
    end

    // Skid contents are only observable through vld_skid, so they carry no reset.
    always_ff @(posedge clock) begin
        if (load_skid) begin
            a_skid    <= a_p0;
            b_skid    <= b_p0;
            aluc_skid <= aluc_in;
            wreg_skid <= wreg_in;
            rn_skid   <= rn_in;
        end
    end

    assign in_ready  = !vld_skid;
    assign out_valid = vld_p1;
    assign a         = a_p1;
    assign b         = b_p1;
    assign aluc      = aluc_p1;
    assign wreg      = wreg_p1;
    assign rn        = rn_p1;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage; expectations follow EX_FWD_EN when defined.
module tb_ex_operand_stage;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_ready;
    logic [31:0] qa, qb, fwd_data, a, b;
    logic [4:0]  rs, rt, sa, rn_in, fwd_rn, rn;
    logic [15:0] imm;
    logic        shift, aluimm, sext, wreg_in, fwd_valid, out_valid, out_ready, wreg;
    logic [3:0]  aluc_in, aluc;

    int nchk = 0;
    int nerr = 0;

    ex_operand_stage #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .qa(qa), .qb(qb), .rs(rs), .rt(rt), .imm(imm), .sa(sa),
        .shift(shift), .aluimm(aluimm), .sext(sext), .aluc_in(aluc_in),
        .wreg_in(wreg_in), .rn_in(rn_in),
        .fwd_valid(fwd_valid), .fwd_rn(fwd_rn), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .aluc(aluc), .wreg(wreg), .rn(rn)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [4:0] vrs,
                         input logic [4:0] vrt, input logic [15:0] vimm, input logic [4:0] vsa,
                         input logic vshift, input logic valuimm, input logic vsext,
                         input logic [3:0] valuc);
        in_valid = 1'b1;
        qa = va; qb = vb; rs = vrs; rt = vrt; imm = vimm; sa = vsa;
        shift = vshift; aluimm = valuimm; sext = vsext; aluc_in = valuc;
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    logic [31:0] exp_fwd_a, exp_fwd_b;

    initial begin
`ifdef EX_FWD_EN
        exp_fwd_a = 32'h0000DEAD;
        exp_fwd_b = 32'h0000DEAD;
`else
        exp_fwd_a = 32'd1;
        exp_fwd_b = 32'd2;
`endif
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        qa = '0; qb = '0; rs = '0; rt = '0; imm = '0; sa = '0;
        shift = 0; aluimm = 0; sext = 0; aluc_in = '0; wreg_in = 0; rn_in = '0;
        fwd_valid = 0; fwd_rn = '0; fwd_data = '0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
        chk("rst_a",         a,                  32'd0);
        chk("rst_b",         b,                  32'd0);
        chk("rst_aluc",      {28'b0, aluc},      32'd0);
        chk("rst_wreg_rn",   {26'b0, wreg, rn},  32'd0);

        // Basic register operands, then back-to-back immediate/shift variants.
        issue(32'd5, 32'd7, 5'd1, 5'd2, 16'h0000, 5'd0, 0, 0, 0, 4'b0000);
        wreg_in = 1'b1; rn_in = 5'd9;
        step();
        chk("reg_valid", {31'b0, out_valid}, 32'd1);
        chk("reg_a",     a,                  32'd5);
        chk("reg_b",     b,                  32'd7);
        chk("reg_aluc",  {28'b0, aluc},      32'd0);
        chk("reg_wreg_rn", {26'b0, wreg, rn}, {26'b0, 1'b1, 5'd9});

        issue(32'd5, 32'd99, 5'd1, 5'd2, 16'h8001, 5'd0, 0, 1, 1, 4'b0010);
        wreg_in = 1'b0; rn_in = 5'd3;
        step();
        chk("sext_b",    b,             32'hFFFF8001);
        chk("sext_aluc", {28'b0, aluc}, 32'd2);
        chk("sext_rn",   {27'b0, rn},   32'd3);

        issue(32'd5, 32'd99, 5'd1, 5'd2, 16'h8001, 5'd0, 0, 1, 0, 4'b0011);
        step();
        chk("zext_b", b, 32'h00008001);

        issue(32'h12345678, 32'd7, 5'd1, 5'd2, 16'h0000, 5'd3, 1, 0, 0, 4'b1010);
        step();
        chk("shift_a", a, 32'd3);
        chk("shift_b", b, 32'd7);

        // Forwarding hit on rs, then rs=0 never forwarded, then hit on rt.
        issue(32'd1, 32'd2, 5'd4, 5'd5, 16'h0000, 5'd0, 0, 0, 0, 4'b0000);
        fwd_valid = 1'b1; fwd_rn = 5'd4; fwd_data = 32'h0000DEAD;
        step();
        chk("fwd_rs_a", a, exp_fwd_a);
        chk("fwd_rs_b", b, 32'd2);

        issue(32'd1, 32'd2, 5'd0, 5'd5, 16'h0000, 5'd0, 0, 0, 0, 4'b0000);
        fwd_rn = 5'd0;
        step();
        chk("fwd_r0_a", a, 32'd1);

        issue(32'd1, 32'd2, 5'd3, 5'd7, 16'h0000, 5'd0, 0, 0, 0, 4'b0000);
        fwd_rn = 5'd7;
        step();
        chk("fwd_rt_b", b, exp_fwd_b);
        chk("fwd_rt_a", a, 32'd1);

        in_valid = 1'b0; fwd_valid = 1'b0;
        step();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: I0..I3 with out_ready low for three cycles.
        out_ready = 1'b0;
        issue(32'd100, 32'd0, 5'd1, 5'd2, 16'h0, 5'd0, 0, 0, 0, 4'b0000);
        step();
        chk("bp_i0_a",     a,                  32'd100);
        chk("bp_i0_rdy",   {31'b0, in_ready},  32'd1);
        qa = 32'd101;
        step();
        chk("bp_hold_a",   a,                  32'd100);
        chk("bp_hold_rdy", {31'b0, in_ready},  32'd0);
        qa = 32'd102;
        step();
        chk("bp_hold2_a",  a,                  32'd100);
        chk("bp_hold2_vld", {31'b0, out_valid}, 32'd1);
        chk("bp_hold2_rdy", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_i1_a",     a,                  32'd101);
        chk("bp_i1_rdy",   {31'b0, in_ready},  32'd1);
        step();
        chk("bp_i2_a",     a,                  32'd102);
        chk("bp_i2_vld",   {31'b0, out_valid}, 32'd1);
        qa = 32'd103;
        step();
        chk("bp_i3_a",     a,                  32'd103);
        chk("bp_i3_vld",   {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_end_vld",  {31'b0, out_valid}, 32'd0);

        // Flush with skid full and in_valid high.
        out_ready = 1'b0;
        issue(32'd200, 32'd0, 5'd1, 5'd2, 16'h0, 5'd0, 0, 0, 0, 4'b0000);
        step();
        qa = 32'd201;
        step();
        chk("fl_skid_rdy", {31'b0, in_ready}, 32'd0);
        qa = 32'd202; flush = 1'b1;
        step();
        chk("fl_vld", {31'b0, out_valid}, 32'd0);
        chk("fl_rdy", {31'b0, in_ready},  32'd1);
        qa = 32'd300;
        step();
        chk("fl_acc_vld", {31'b0, out_valid}, 32'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_after_vld", {31'b0, out_valid}, 32'd0);

        // Reset mid-operation drops the held entry and clears data outputs.
        out_ready = 1'b0;
        issue(32'd400, 32'd401, 5'd1, 5'd2, 16'h0, 5'd0, 0, 0, 0, 4'b0110);
        step();
        chk("mid_a", a, 32'd400);
        in_valid = 1'b0; reset = 1'b1;
        step();
        chk("mid_rst_vld", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_a",   a,                  32'd0);
        chk("mid_rst_aluc", {28'b0, aluc},     32'd0);
        chk("mid_rst_rdy", {31'b0, in_ready},  32'd1);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
